// File: rtl/move_controller.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | move_controller: turn/move sequencer for a 3x3 three-in-a-row board.   |
// | Rev 1.0 - initial release                                              |
// +------------------------------------------------------------------------+
module move_controller #(
  parameter logic FIRST_PLAYER = 1'b0,
  parameter logic ILL_ON_OVER  = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       move_valid,
  input  logic [3:0] move_sel,
  input  logic [1:0] pos1,
  input  logic [1:0] pos2,
  input  logic [1:0] pos3,
  input  logic [1:0] pos4,
  input  logic [1:0] pos5,
  input  logic [1:0] pos6,
  input  logic [1:0] pos7,
  input  logic [1:0] pos8,
  input  logic [1:0] pos9,
  output logic [8:0] P1_en,
  output logic [8:0] P2_en,
  output logic       ill_move,
  output logic       turn,
  output logic       game_over,
  output logic [1:0] winner,
  output logic [3:0] move_count
);

  localparam logic [1:0] S_TURN  = 2'd0;
  localparam logic [1:0] S_WRITE = 2'd1;
  localparam logic [1:0] S_EVAL  = 2'd2;
  localparam logic [1:0] S_OVER  = 2'd3;

  logic [1:0] state_q, state_d;
  logic [8:0] p1_en_q, p1_en_d;
  logic [8:0] p2_en_q, p2_en_d;
  logic       ill_move_q, ill_move_d;
  logic       turn_q, turn_d;
  logic       game_over_q, game_over_d;
  logic [1:0] winner_q, winner_d;
  logic [3:0] move_count_q, move_count_d;

  logic [8:0][1:0] board;
  logic [1:0]      sel_cell;
  logic            sel_in_range;
  logic            move_legal;
  logic [8:0]      sel_onehot;
  logic [1:0]      win_code;

  assign board = {pos9, pos8, pos7, pos6, pos5, pos4, pos3, pos2, pos1};

  function automatic logic [1:0] line_owner(input logic [1:0] a, input logic [1:0] b,
                                            input logic [1:0] c);
    return ((a != 2'b00) && (a == b) && (b == c)) ? a : 2'b00;
  endfunction

  always_comb begin
    sel_cell = 2'b00;
    for (int k = 0; k < 9; k++) begin
      if (move_sel == 4'(k + 1)) sel_cell = board[k];
    end
  end

  assign sel_in_range = (move_sel >= 4'd1) && (move_sel <= 4'd9);
  assign move_legal   = move_valid && sel_in_range && (sel_cell == 2'b00);
  assign sel_onehot   = 9'd1 << (move_sel - 4'd1);

  always_comb begin
    win_code = 2'b00;
    win_code = win_code | line_owner(board[0], board[1], board[2]);
    win_code = win_code | line_owner(board[3], board[4], board[5]);
    win_code = win_code | line_owner(board[6], board[7], board[8]);
    win_code = win_code | line_owner(board[0], board[3], board[6]);
    win_code = win_code | line_owner(board[1], board[4], board[7]);
    win_code = win_code | line_owner(board[2], board[5], board[8]);
    win_code = win_code | line_owner(board[0], board[4], board[8]);
    win_code = win_code | line_owner(board[2], board[4], board[6]);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_TURN;
      p1_en_q      <= '0;
      p2_en_q      <= '0;
      ill_move_q   <= 1'b0;
      turn_q       <= FIRST_PLAYER;
      game_over_q  <= 1'b0;
      winner_q     <= 2'b00;
      move_count_q <= 4'd0;
    end else begin
      state_q      <= state_d;
      p1_en_q      <= p1_en_d;
      p2_en_q      <= p2_en_d;
      ill_move_q   <= ill_move_d;
      turn_q       <= turn_d;
      game_over_q  <= game_over_d;
      winner_q     <= winner_d;
      move_count_q <= move_count_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_TURN:  if (move_legal) state_d = S_WRITE;
      S_WRITE: state_d = S_EVAL;
      S_EVAL:  if ((win_code != 2'b00) || (move_count_q == 4'd9)) state_d = S_OVER;
               else state_d = S_TURN;
      default: state_d = S_OVER;
    endcase
  end

  // Enables and ill_move default low so each is a single-cycle pulse.
  always_comb begin
    p1_en_d      = '0;
    p2_en_d      = '0;
    ill_move_d   = 1'b0;
    turn_d       = turn_q;
    game_over_d  = game_over_q;
    winner_d     = winner_q;
    move_count_d = move_count_q;
    case (state_q)
      S_TURN: begin
        if (move_legal) begin
          if (turn_q) p2_en_d = sel_onehot;
          else        p1_en_d = sel_onehot;
          move_count_d = move_count_q + 4'd1;
        end else if (move_valid) begin
          ill_move_d = 1'b1;
        end
      end
      S_EVAL: begin
        if (win_code != 2'b00) begin
          game_over_d = 1'b1;
          winner_d    = win_code;
        end else if (move_count_q == 4'd9) begin
          game_over_d = 1'b1;
          winner_d    = 2'b11;
        end else begin
          turn_d = ~turn_q;
        end
      end
      S_OVER: ill_move_d = move_valid && ILL_ON_OVER;
      default: ;
    endcase
  end

  assign P1_en      = p1_en_q;
  assign P2_en      = p2_en_q;
  assign ill_move   = ill_move_q;
  assign turn       = turn_q;
  assign game_over  = game_over_q;
  assign winner     = winner_q;
  assign move_count = move_count_q;

endmodule
`default_nettype wire

// File: tb/tb_move_controller.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | tb_move_controller: scoreboard bench for move_controller.              |
// | Rev 1.0 - initial release                                              |
// +------------------------------------------------------------------------+
module tb_move_controller;

  typedef struct packed {
    logic [8:0] p1;
    logic [8:0] p2;
    logic       ill;
    logic       turn;
    logic       go;
    logic [1:0] win;
    logic [3:0] cnt;
  } snap_t;

  localparam snap_t RESET_SNAP = '{p1: 9'd0, p2: 9'd0, ill: 1'b0, turn: 1'b0,
                                   go: 1'b0, win: 2'b00, cnt: 4'd0};

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       move_valid = 1'b0;
  logic [3:0] move_sel = 4'd0;
  logic [1:0] pos [9];
  logic [8:0] P1_en, P2_en;
  logic       ill_move, turn, game_over;
  logic [1:0] winner;
  logic [3:0] move_count;

  int checks = 0;
  int failures = 0;

  snap_t exp_q[$];
  snap_t mdl;
  int    mdl_board [9];
  int    lines [8][3] = '{'{0,1,2}, '{3,4,5}, '{6,7,8}, '{0,3,6},
                          '{1,4,7}, '{2,5,8}, '{0,4,8}, '{2,4,6}};

  logic  mon_on = 1'b0;
  logic  mon_first = 1'b0;
  snap_t prev, cur, e;

  always #5 clk = ~clk;

  move_controller dut (
    .clk(clk), .reset(reset), .move_valid(move_valid), .move_sel(move_sel),
    .pos1(pos[0]), .pos2(pos[1]), .pos3(pos[2]), .pos4(pos[3]), .pos5(pos[4]),
    .pos6(pos[5]), .pos7(pos[6]), .pos8(pos[7]), .pos9(pos[8]),
    .P1_en(P1_en), .P2_en(P2_en), .ill_move(ill_move), .turn(turn),
    .game_over(game_over), .winner(winner), .move_count(move_count)
  );

  // Board position registers, written by the DUT enables.
  always @(posedge clk) begin
    for (int k = 0; k < 9; k++) begin
      if (reset)         pos[k] <= 2'b00;
      else if (P1_en[k]) pos[k] <= 2'b01;
      else if (P2_en[k]) pos[k] <= 2'b10;
    end
  end

  // Monitor: every change of the observable outputs pops one expected snapshot.
  always @(negedge clk) begin
    if (mon_on) begin
      cur = '{p1: P1_en, p2: P2_en, ill: ill_move, turn: turn, go: game_over,
              win: winner, cnt: move_count};
      if (mon_first || cur != prev) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_change got p1=%h p2=%h ill=%b turn=%b go=%b win=%b cnt=%0d, required no change",
                   cur.p1, cur.p2, cur.ill, cur.turn, cur.go, cur.win, cur.cnt);
        end else begin
          e = exp_q.pop_front();
          if (cur != e) begin
            failures++;
            $display("FAIL snapshot got p1=%h p2=%h ill=%b turn=%b go=%b win=%b cnt=%0d required p1=%h p2=%h ill=%b turn=%b go=%b win=%b cnt=%0d",
                     cur.p1, cur.p2, cur.ill, cur.turn, cur.go, cur.win, cur.cnt,
                     e.p1, e.p2, e.ill, e.turn, e.go, e.win, e.cnt);
          end
        end
      end
      prev = cur;
      mon_first = 1'b0;
    end
  end

  task automatic expect_snap(input snap_t s);
    if (s != mdl) begin
      exp_q.push_back(s);
      mdl = s;
    end
  endtask

  task automatic check(input string name, input int got, input int req);
    checks++;
    if (got != req) begin
      failures++;
      $display("FAIL %s got=%0d required=%0d", name, got, req);
    end
  endtask

  function automatic int model_win();
    for (int l = 0; l < 8; l++) begin
      if (mdl_board[lines[l][0]] != 0 &&
          mdl_board[lines[l][0]] == mdl_board[lines[l][1]] &&
          mdl_board[lines[l][1]] == mdl_board[lines[l][2]])
        return mdl_board[lines[l][0]];
    end
    return 0;
  endfunction

  // Issue one strobe; with hold=1 the strobe stays up through WRITE and EVAL using hold_sel.
  task automatic issue(input int sel, input bit hold, input int hold_sel);
    snap_t s;
    int    w;
    s = mdl;
    if (mdl.go) begin
      s.ill = 1'b1; expect_snap(s);
      s.ill = 1'b0; expect_snap(s);
    end else if (sel < 1 || sel > 9 || mdl_board[sel-1] != 0) begin
      s.ill = 1'b1; expect_snap(s);
      s.ill = 1'b0; expect_snap(s);
    end else begin
      if (mdl.turn) s.p2 = 9'(1 << (sel - 1));
      else          s.p1 = 9'(1 << (sel - 1));
      s.cnt = mdl.cnt + 4'd1;
      expect_snap(s);
      s.p1 = '0; s.p2 = '0;
      expect_snap(s);
      mdl_board[sel-1] = mdl.turn ? 2 : 1;
      w = model_win();
      if (w != 0)              begin s.go = 1'b1; s.win = 2'(w); end
      else if (s.cnt == 4'd9)  begin s.go = 1'b1; s.win = 2'b11; end
      else                     s.turn = ~s.turn;
      expect_snap(s);
    end
    @(posedge clk); #1;
    move_valid = 1'b1;
    move_sel   = 4'(sel);
    @(posedge clk); #1;
    if (hold) begin
      move_sel = 4'(hold_sel);
      repeat (2) @(posedge clk);
      #1;
    end
    move_valid = 1'b0;
    repeat (3) @(posedge clk);
  endtask

  task automatic do_reset();
    expect_snap(RESET_SNAP);
    for (int k = 0; k < 9; k++) mdl_board[k] = 0;
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    repeat (2) @(posedge clk);
  endtask

  initial begin
    int seq [9] = '{1, 2, 3, 5, 4, 7, 8, 6, 9};
    for (int k = 0; k < 9; k++) mdl_board[k] = 0;
    repeat (3) @(posedge clk);
    mdl = RESET_SNAP;
    exp_q.push_back(RESET_SNAP);
    #1 reset = 1'b0;
    mon_first = 1'b1;
    mon_on    = 1'b1;
    repeat (2) @(posedge clk);

    // First move, occupied cell, and out-of-range selections.
    issue(1, 0, 0);
    issue(5, 0, 0);
    issue(4, 0, 0);
    issue(4, 0, 0);
    issue(0, 0, 0);
    issue(10, 0, 0);
    issue(15, 0, 0);
    #1;
    check("turn_after_illegal", turn, 1);
    check("count_after_illegal", move_count, 3);

    // P1 wins on the top row; strobes during WRITE/EVAL are ignored.
    do_reset();
    issue(1, 1, 9);
    issue(4, 1, 8);
    issue(2, 0, 0);
    issue(5, 0, 0);
    issue(3, 0, 0);
    #1;
    check("win_winner", winner, 1);
    check("win_game_over", game_over, 1);
    check("win_count", move_count, 5);
    issue(7, 0, 0);

    // Full-board draw.
    do_reset();
    foreach (seq[i]) issue(seq[i], 0, 0);
    #1;
    check("draw_winner", winner, 3);
    check("draw_game_over", game_over, 1);
    check("draw_count", move_count, 9);
    issue(1, 0, 0);

    // Reset arriving during WRITE must leave no partial move.
    do_reset();
    begin
      snap_t s;
      s = mdl; s.p1 = 9'b000010000; s.cnt = 4'd1;
      expect_snap(s);
      expect_snap(RESET_SNAP);
    end
    @(posedge clk); #1;
    move_valid = 1'b1; move_sel = 4'd5;
    @(posedge clk); #1;
    move_valid = 1'b0; reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("reset_write_cell5", pos[4], 0);
    check("reset_write_p1en", P1_en, 0);
    repeat (3) @(posedge clk);
    #1;
    check("queue_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
